// File: rtl/cic_pkg.sv
// Shared CIC helpers: register width math and parameter limits.
// Used by the decimator and the planned interpolator.
package cic_pkg;

  localparam int N_MIN = 1;
  localparam int N_MAX = 6;
  localparam int R_MIN = 2;
  localparam int M_MIN = 1;
  localparam int M_MAX = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Hogenauer full-precision width, no pruning
  function automatic int cic_w(
    input int in_w,
    input int n,
    input int r,
    input int m
  );
    return in_w + n * clog2(r * m);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb: M-deep delay line, subtractor, registered output.
// Advances only when the decimated strobe is high.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W       = 28,
  parameter int M_DELAY = 1
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_EN,
  input  logic signed [W-1:0] i_DATA,
  output logic signed [W-1:0] o_DATA
);

  logic signed [W-1:0] r_dly [M_DELAY];
  logic signed [W-1:0] r_out;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int k = 0; k < M_DELAY; k++) begin
        r_dly[k] <= '0;
      end
      r_out <= '0;
    end else if (i_EN) begin
      r_dly[0] <= i_DATA;
      for (int k = 1; k < M_DELAY; k++) begin
        r_dly[k] <= r_dly[k-1];
      end
      r_out <= i_DATA - r_dly[M_DELAY-1];
    end
  end

  assign o_DATA = r_out;

endmodule

// File: rtl/cic_decimator_param.sv
// N-stage CIC decimator, rate R, differential delay M.
// Full-precision modulo arithmetic; output is the MSB slice.
module cic_decimator_param
  import cic_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int N_STAGES = 3,
  parameter int R_RATE   = 16,
  parameter int M_DELAY  = 1
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_VALID,
  input  logic signed [IN_W-1:0]  i_DATA,
  output logic                    o_VALID,
  output logic signed [OUT_W-1:0] o_DATA
);

  localparam int W  = cic_w(IN_W, N_STAGES, R_RATE, M_DELAY);
  localparam int CB = clog2(R_RATE);
  localparam int CW = (CB < 1) ? 1 : CB;
  localparam int SH = W - OUT_W;
  localparam logic [CW-1:0] LAST = CW'(R_RATE - 1);

  if (R_RATE < R_MIN) begin : g_bad_r
    $error("cic_decimator_param: R_RATE must be >= 2");
  end
  if (M_DELAY < M_MIN || M_DELAY > M_MAX) begin : g_bad_m
    $error("cic_decimator_param: M_DELAY must be 1 or 2");
  end
  if (N_STAGES < N_MIN || N_STAGES > N_MAX) begin : g_bad_n
    $error("cic_decimator_param: N_STAGES must be 1..6");
  end
  if (OUT_W > W) begin : g_bad_w
    $error("cic_decimator_param: OUT_W exceeds internal width");
  end

  logic signed [W-1:0] w_x;
  logic signed [W-1:0] r_int [N_STAGES];
  logic [CW-1:0]       r_cnt;
  logic                r_dec_stb;
  logic                r_cmb_stb;
  logic signed [W-1:0] r_c0;
  logic [N_STAGES:0][W-1:0] w_c;
  logic signed [W-1:0] w_last;

  assign w_x = {{(W-IN_W){i_DATA[IN_W-1]}}, i_DATA};

  // Integrator chain reads last-cycle values of the stage before
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int k = 0; k < N_STAGES; k++) begin
        r_int[k] <= '0;
      end
    end else if (i_VALID) begin
      r_int[0] <= r_int[0] + w_x;
      for (int k = 1; k < N_STAGES; k++) begin
        r_int[k] <= r_int[k] + r_int[k-1];
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_cnt     <= '0;
      r_dec_stb <= 1'b0;
    end else begin
      r_dec_stb <= 1'b0;
      if (i_VALID) begin
        if (r_cnt == LAST) begin
          r_cnt     <= '0;
          r_dec_stb <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_c0      <= '0;
      r_cmb_stb <= 1'b0;
    end else begin
      r_cmb_stb <= r_dec_stb;
      if (r_dec_stb) r_c0 <= r_int[N_STAGES-1];
    end
  end

  assign w_c[0] = r_c0;

  for (genvar k = 1; k <= N_STAGES; k++) begin : g_comb
    cic_comb_stage #(
      .W      (W),
      .M_DELAY(M_DELAY)
    ) u_comb (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .i_EN  (r_dec_stb),
      .i_DATA($signed(w_c[k-1])),
      .o_DATA(w_c[k])
    );
  end

  assign w_last = $signed(w_c[N_STAGES]);

  // Combs settle on the strobe edge; publish their result one edge later
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_VALID <= 1'b0;
      o_DATA  <= '0;
    end else begin
      o_VALID <= r_cmb_stb;
      if (r_cmb_stb) o_DATA <= OUT_W'(w_last >>> SH);
    end
  end

endmodule
